char_plotter: RTL and testbench



---
 rtl/char_plotter_pkg.sv | 33 +++
 rtl/char_plotter_if.sv | 32 +++
 rtl/char_plotter_glyph_rom.sv | 50 +++++
 rtl/char_plotter.sv | 115 +++++++++++
 tb/tb_char_plotter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/char_plotter_pkg.sv
// Shared definitions for the hex glyph plotter.
// Holds the glyph geometry and the bus field widths.
// Holds the FSM state encoding and the default frame size.
// Holds the request record that is latched when a glyph is accepted.
package pixeltyper_pkg;

    localparam int GLYPH_W  = 5;
    localparam int GLYPH_H  = 7;
    localparam int CHAR_W   = 4;
    localparam int COLOUR_W = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int ROM_AW   = CHAR_W + 3;   // {char_code, row}

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLOT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Everything captured from the requester when a glyph is accepted.
    typedef struct packed {
        logic [CHAR_W-1:0]   char_code;
        logic [X_W-1:0]      x0;
        logic [Y_W-1:0]      y0;
        logic [COLOUR_W-1:0] colour;
    } glyph_req_t;

endpackage

// File: rtl/char_plotter_if.sv
// Request/response bus between the word sequencer and char_plotter.
// The bus also carries the pixel stream that feeds vga_adapter.
//   start, char_code, x0, y0, colour : request from the sequencer
//   busy, done                       : handshake status from the plotter
//   vga_x, vga_y, vga_colour, vga_plot : pixel write to vga_adapter
// master = requester / pixel consumer side, slave = char_plotter.
interface char_plotter_if;
    import pixeltyper_pkg::*;

    logic                start;
    logic [CHAR_W-1:0]   char_code;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [COLOUR_W-1:0] colour;
    logic                busy;
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        output start, char_code, x0, y0, colour,
        input  busy, done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, char_code, x0, y0, colour,
        output busy, done, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/char_plotter_glyph_rom.sv
// glyph_rom: the 5x7 hex font (0-F) as a synchronous-read ROM.
//   clk  : clock
//   addr : {char_code, row}; row 0 is the top row, and row 7 reads as blank
//   data : the 5 pixel bits of that row, registered (1-cycle latency);
//          bit 4 is the leftmost column
module glyph_rom
    import pixeltyper_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [GLYPH_W-1:0] data
);

    logic [CHAR_W-1:0] char_sel;
    logic [2:0]        row_sel;
    // g[7] is the top row and g[0] is a blank pad.
    // The pad lets the unused row index 7 read as zero without a range check.
    logic [7:0][GLYPH_W-1:0] g;

    assign char_sel = addr[ROM_AW-1:3];
    assign row_sel  = addr[2:0];

    always_comb begin
        g = '0;
        case (char_sel)
            4'h0: g = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E, 5'h00};
            4'h1: g = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E, 5'h00};
            4'h2: g = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F, 5'h00};
            4'h3: g = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E, 5'h00};
            4'h4: g = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02, 5'h00};
            4'h5: g = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E, 5'h00};
            4'h6: g = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E, 5'h00};
            4'h7: g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08, 5'h00};
            4'h8: g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E, 5'h00};
            4'h9: g = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C, 5'h00};
            4'hA: g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h00};
            4'hB: g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E, 5'h00};
            4'hC: g = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E, 5'h00};
            4'hD: g = {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C, 5'h00};
            4'hE: g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F, 5'h00};
            4'hF: g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10, 5'h00};
            default: g = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        data <= g[3'd7 - row_sel];
    end

endmodule

// File: rtl/char_plotter.sv
// char_plotter: draws one 5x7 hex glyph into the frame buffer.
// It plots one pixel per clock and drives vga_adapter directly.
//   clk    : system clock
//   resetn : synchronous active-low reset
//   bus    : char_plotter_if.slave, which carries these signals:
//            start/char_code/x0/y0/colour are the request inputs
//            busy/done are the handshake outputs
//            vga_x/vga_y/vga_colour/vga_plot are the pixel outputs
// Each glyph row costs one FETCH cycle (ROM read) followed by five PLOT cycles.
// A glyph therefore takes a fixed 44 cycles from acceptance back to IDLE.
// Pixels that fall off the screen are suppressed, but they still take their
// cycle, so the timing does not depend on the glyph position.
module char_plotter
    import pixeltyper_pkg::*;
#(
    parameter int                  SCREEN_W  = DEF_SCREEN_W,
    parameter int                  SCREEN_H  = DEF_SCREEN_H,
    parameter bit                  DRAW_BG   = 1'b1,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
)(
    input  logic          clk,
    input  logic          resetn,
    char_plotter_if.slave bus
);

    localparam logic [2:0]   COL_LAST = 3'(GLYPH_W - 1);
    localparam logic [2:0]   ROW_LAST = 3'(GLYPH_H - 1);
    localparam logic [X_W:0] X_LIM    = SCREEN_W[X_W:0];
    localparam logic [Y_W:0] Y_LIM    = SCREEN_H[Y_W:0];

    state_t              state, state_nxt;
    glyph_req_t          req_q;
    logic [2:0]          row_q, col_q;
    logic [GLYPH_W-1:0]  row_bits;

    // These registers hold the last pixel position and colour driven.
    // The outputs keep that pixel outside PLOT.
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] c_q;

    // The coordinates carry one extra bit so that a glyph overhanging the
    // right or bottom edge is clipped rather than wrapping to column/row 0.
    logic [X_W:0]        px;
    logic [Y_W:0]        py;
    logic                pix_bit, in_bounds;
    logic [COLOUR_W-1:0] pix_colour;

    glyph_rom u_rom (
        .clk  (clk),
        .addr ({req_q.char_code, row_q}),
        .data (row_bits)
    );

    assign px         = {1'b0, req_q.x0} + {{(X_W-2){1'b0}}, col_q};
    assign py         = {1'b0, req_q.y0} + {{(Y_W-2){1'b0}}, row_q};
    assign pix_bit    = row_bits[COL_LAST - col_q];
    assign in_bounds  = (px < X_LIM) && (py < Y_LIM);
    assign pix_colour = pix_bit ? req_q.colour : BG_COLOUR;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = FETCH;
            FETCH:   state_nxt = PLOT;
            PLOT:    if (col_q == COL_LAST)
                         state_nxt = (row_q == ROW_LAST) ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            req_q <= '0;
            row_q <= '0;
            col_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            c_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        req_q <= '{char_code: bus.char_code, x0: bus.x0,
                                   y0: bus.y0, colour: bus.colour};
                        row_q <= '0;
                    end
                end
                FETCH: col_q <= '0;
                PLOT: begin
                    x_q <= px[X_W-1:0];
                    y_q <= py[Y_W-1:0];
                    c_q <= pix_colour;
                    if (col_q == COL_LAST) begin
                        if (row_q != ROW_LAST) row_q <= row_q + 3'd1;
                    end else begin
                        col_q <= col_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.vga_plot   = (state == PLOT) && in_bounds && (pix_bit || DRAW_BG);
    assign bus.vga_x      = (state == PLOT) ? px[X_W-1:0] : x_q;
    assign bus.vga_y      = (state == PLOT) ? py[Y_W-1:0] : y_q;
    assign bus.vga_colour = (state == PLOT) ? pix_colour  : c_q;

endmodule

// File: tb/tb_char_plotter.sv
module tb_char_plotter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    char_plotter_if ifa ();
    char_plotter_if ifb ();

    assign ifb.start     = ifa.start;
    assign ifb.char_code = ifa.char_code;
    assign ifb.x0        = ifa.x0;
    assign ifb.y0        = ifa.y0;
    assign ifb.colour    = ifa.colour;

    char_plotter #(.DRAW_BG(1'b1)) dut_bg (.clk(clk), .resetn(resetn), .bus(ifa.slave));
    char_plotter #(.DRAW_BG(1'b0)) dut_fg (.clk(clk), .resetn(resetn), .bus(ifb.slave));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // The font as rows of pixels; bit 4 is the leftmost column.
    logic [4:0] font [16][7] = '{
        '{5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E},
        '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},
        '{5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F},
        '{5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E},
        '{5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},
        '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},
        '{5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},
        '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},
        '{5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},
        '{5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C},
        '{5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11},
        '{5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E},
        '{5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E},
        '{5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C},
        '{5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F},
        '{5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10}
    };

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int pix_bit(input int c, input int r, input int k);
        return int'(font[c][r][4-k]);
    endfunction

    // Expected number of plotted pixels for one glyph, straight from the rules.
    function automatic int model_count(input int c, input int x, input int y, input bit bg);
        int n = 0;
        for (int r = 0; r < 7; r++)
            for (int k = 0; k < 5; k++)
                if ((x + k) < 160 && (y + r) < 120 && (pix_bit(c, r, k) == 1 || bg)) n++;
        return n;
    endfunction

    // Reference model: m_t is the cycle number since the last acceptance.
    // A value of -1 or 44 means the plotter is idle.
    int m_t = -1;
    int m_c = 0, m_x = 0, m_y = 0, m_col = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!resetn) m_t = -1;
        else if (m_t < 1 || m_t >= 44) begin
            if (ifa.start) begin
                m_c = int'(ifa.char_code); m_x = int'(ifa.x0);
                m_y = int'(ifa.y0);        m_col = int'(ifa.colour);
                m_t = 1;
            end else m_t = -1;
        end else m_t++;
    end

    int cnt_bg, cnt_fg, fx, fy, lx, ly, overlaps;
    bit first_seen;
    bit painted [160][120];
    int stamps [$];

    task automatic clear_stats();
        cnt_bg = 0; cnt_fg = 0; first_seen = 0; overlaps = 0;
        fx = -1; fy = -1; lx = -1; ly = -1;
        stamps.delete();
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) painted[i][j] = 1'b0;
    endtask

    // Cycle monitor: compares both DUTs against the model on every falling edge.
    initial begin : mon
        bit in_plot, inb, e_bg, e_fg;
        int r, k, b, xx, yy;
        forever begin
            @(negedge clk);
            in_plot = (m_t >= 2 && m_t <= 42 && ((m_t - 2) % 6) < 5);
            r  = in_plot ? (m_t - 2) / 6 : 0;
            k  = in_plot ? (m_t - 2) % 6 : 0;
            b  = pix_bit(m_c, r, k);
            xx = m_x + k;
            yy = m_y + r;
            inb  = (xx < 160) && (yy < 120);
            e_bg = in_plot && inb;
            e_fg = in_plot && inb && (b == 1);
            check("busy_bg", int'(ifa.busy), int'(m_t >= 1 && m_t <= 43));
            check("busy_fg", int'(ifb.busy), int'(m_t >= 1 && m_t <= 43));
            check("done_bg", int'(ifa.done), int'(m_t == 43));
            check("done_fg", int'(ifb.done), int'(m_t == 43));
            check("plot_bg", int'(ifa.vga_plot), int'(e_bg));
            check("plot_fg", int'(ifb.vga_plot), int'(e_fg));
            if (e_bg && ifa.vga_plot) begin
                check("x_bg", int'(ifa.vga_x), xx % 256);
                check("y_bg", int'(ifa.vga_y), yy % 128);
                check("colour_bg", int'(ifa.vga_colour), (b == 1) ? m_col : 0);
            end
            if (e_fg && ifb.vga_plot) begin
                check("x_fg", int'(ifb.vga_x), xx % 256);
                check("y_fg", int'(ifb.vga_y), yy % 128);
                check("colour_fg", int'(ifb.vga_colour), m_col);
            end
            if (ifa.vga_plot) begin
                cnt_bg++;
                if (!first_seen) begin fx = int'(ifa.vga_x); fy = int'(ifa.vga_y); first_seen = 1; end
                lx = int'(ifa.vga_x); ly = int'(ifa.vga_y);
                if (ifa.vga_x < 160 && ifa.vga_y < 120) begin
                    if (painted[ifa.vga_x][ifa.vga_y]) overlaps++;
                    painted[ifa.vga_x][ifa.vga_y] = 1'b1;
                end
            end
            if (ifb.vga_plot) cnt_fg++;
            if (ifa.done) stamps.push_back(cyc);
        end
    end

    // Start one glyph and wait for done, then advance into the idle cycle.
    // lat is the number of cycles from acceptance to done; 100 means it timed out.
    task automatic run_glyph(input int c, input int x, input int y, input int col,
                             input bit noise, output int lat);
        ifa.char_code = 4'(c); ifa.x0 = 8'(x); ifa.y0 = 7'(y); ifa.colour = 3'(col);
        ifa.start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) ifa.start = 1'b0;
            if (noise && lat >= 2 && lat <= 40) begin
                ifa.start     = 1'($urandom_range(1));
                ifa.char_code = 4'($urandom_range(15));
                ifa.x0        = 8'($urandom);
            end
            if (noise && lat == 41) ifa.start = 1'b0;
        end while (!ifa.done && lat < 100);
        @(negedge clk);
    endtask

    typedef struct {
        int c, x, y, col;
        int n_bg, n_fg;
        int fx, fy, lx, ly;
    } vec_t;
    vec_t vt [3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        ifa.start = 1'b0; ifa.char_code = '0; ifa.x0 = '0; ifa.y0 = '0; ifa.colour = '0;
        clear_stats();

        // Check the reset state.
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x", int'(ifa.vga_x), 0);
        check("rst_y", int'(ifa.vga_y), 0);
        check("rst_colour", int'(ifa.vga_colour), 0);
        check("rst_plot_fg", int'(ifb.vga_plot), 0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed glyphs.
        // Fields: char, x0, y0, colour, plots with bg, plots fg-only,
        // then the first and last plotted pixel.
        vt[0] = '{1,  10,  20,  4, 35, 10, 10,  20,  14,  26};
        vt[1] = '{8,   0,   0,  2, 35, 17,  0,   0,   4,   6};
        vt[2] = '{15, 157, 116, 5, 12,  8, 157, 116, 159, 119};
        foreach (vt[i]) begin
            clear_stats();
            run_glyph(vt[i].c, vt[i].x, vt[i].y, vt[i].col, 1'b0, lat);
            check("done_latency", lat, 43);
            check("count_bg", cnt_bg, vt[i].n_bg);
            check("count_fg", cnt_fg, vt[i].n_fg);
            check("first_x", fx, vt[i].fx);
            check("first_y", fy, vt[i].fy);
            check("last_x", lx, vt[i].lx);
            check("last_y", ly, vt[i].ly);
        end

        // Hold start high while busy and change the char.
        // Glyph 3 is drawn first; glyph A is accepted only once the plotter is idle.
        clear_stats();
        ifa.char_code = 4'h3; ifa.x0 = 8'd30; ifa.y0 = 7'd40; ifa.colour = 3'd1;
        ifa.start = 1'b1;
        for (int k = 1; k <= 88; k++) begin
            @(negedge clk);
            if (k == 5)  begin ifa.char_code = 4'hA; ifa.x0 = 8'd50; end
            if (k == 43) check("hold_done1", int'(ifa.done), 1);
            if (k == 44) check("hold_idle_gap", int'(ifa.busy), 0);
            if (k == 45) check("hold_rearm", int'(ifa.busy), 1);
            if (k == 46) ifa.start = 1'b0;
            if (k == 87) check("hold_done2", int'(ifa.done), 1);
        end
        check("hold_fg_pixels", cnt_fg, 32);
        check("hold_done_count", stamps.size(), 2);

        // Reset mid-glyph.
        clear_stats();
        ifa.char_code = 4'h5; ifa.x0 = 8'd60; ifa.y0 = 7'd60; ifa.colour = 3'd6;
        ifa.start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) ifa.start = 1'b0;
            if (k == 20) resetn = 1'b0;
            if (k == 21) begin
                check("abort_busy", int'(ifa.busy), 0);
                check("abort_plot", int'(ifa.vga_plot), 0);
                check("abort_done", int'(ifa.done), 0);
                resetn = 1'b1;
            end
        end
        check("abort_no_done", stamps.size(), 0);
        clear_stats();
        run_glyph(5, 60, 60, 6, 1'b0, lat);
        check("after_abort_latency", lat, 43);
        check("after_abort_fg", cnt_fg, 17);

        // Upstream-style run: four glyphs back to back.
        clear_stats();
        for (int g = 0; g < 4; g++) begin
            run_glyph(int'($urandom_range(15)), g * 6, 10, int'($urandom_range(7)), 1'b0, lat);
            check("seq_latency", lat, 43);
        end
        check("seq_done_count", stamps.size(), 4);
        for (int g = 1; g < 4 && g < stamps.size(); g++)
            check("seq_done_spacing", stamps[g] - stamps[g-1], 44);
        check("seq_overlap", overlaps, 0);
        check("seq_count_bg", cnt_bg, 140);

        // Random glyphs, with start noise while busy.
        for (int n = 0; n < 10; n++) begin
            int c, x, y, col;
            c = int'($urandom_range(15)); x = int'($urandom_range(255));
            y = int'($urandom_range(127)); col = int'($urandom_range(7));
            clear_stats();
            repeat ($urandom_range(3)) @(negedge clk);
            run_glyph(c, x, y, col, 1'($urandom_range(1)), lat);
            check("rand_latency", lat, 43);
            check("rand_count_bg", cnt_bg, model_count(c, x, y, 1'b1));
            check("rand_count_fg", cnt_fg, model_count(c, x, y, 1'b0));
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
